mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between two requesters: port I (instruction fetch) and port D (data load/store).
- Sits between the CPU request logic and the memory interface.
- Grants one request at a time and holds the memory command stable until the memory finishes.
- Returns read data with a one-cycle ack pulse, and applies round-robin fairness when both ports request together.

Parameters:
- TIMEOUT, 255, number of WAIT cycles with mem_busy high before the transaction is aborted with an error (1..255; counter is 8 bits).

Ports:
- clk  in  1  clock, rising edge
- nRst  in  1  asynchronous active-low reset
- i_req  in  1  port I request, held until i_ack
- i_adr  in  32  port I address (always a read, sel 4'b1111)
- i_ack  out  1  one-cycle completion pulse, port I
- i_rdata  out  32  port I read data, valid while i_ack=1
- d_req  in  1  port D request, held until d_ack
- d_read  in  1  port D read
- d_write  in  1  port D write
- d_sel  in  4  port D byte enables
- d_adr  in  32  port D address
- d_wdata  in  32  port D write data
- d_ack  out  1  one-cycle completion pulse, port D
- d_rdata  out  32  port D read data, valid while d_ack=1
- err  out  1  one-cycle pulse together with the ack of a timed-out transaction
- mem_busy  in  1  memory processing
- data_from_mem  in  32  memory read data
- read_to_mem  out  1  memory read command
- write_to_mem  out  1  memory write command
- sel_to_mem  out  4  memory byte enables
- adr_to_mem  out  32  memory address
- data_to_mem  out  32  memory write data

Behaviour:
- Reset values: all outputs are 0; state = IDLE; last_grant = D, so port I wins the first tie; timeout counter = 0; the latched command is cleared.
- Reset mid-transaction returns to IDLE immediately. No ack is ever issued for the aborted request.
- States:
  - IDLE: no port requesting → stay. One port requesting → grant it. Both requesting → grant the port that is not last_grant.
    - On grant, latch the command fields: port I = read, sel 1111, i_adr, wdata 0; port D = d_* inputs.
    - Set last_grant.
    - Go to ISSUE, or straight to DONE if the latched command has read=0 and write=0 (no-op; rdata = 0).
  - ISSUE (exactly 1 cycle): drive the latched command onto the *_to_mem outputs → WAIT.
  - WAIT: keep driving the latched command.
    - mem_busy=0 → register data_from_mem into the granted port's rdata register → DONE.
    - mem_busy=1 → increment counter. When counter reaches TIMEOUT, go to DONE with error set and rdata = 0.
  - DONE (exactly 1 cycle): pulse the granted port's ack (plus err if flagged); clear counter and error → IDLE.
- *_to_mem outputs are 0 in IDLE and DONE, and equal the latched command in ISSUE and WAIT.
- If write and read are both set on port D, write wins: write_to_mem=1, read_to_mem=0.
- Request inputs are sampled only in IDLE. Changes to them during a transaction do not affect it.
- A requester keeps req high through its ack. A req still high in the IDLE cycle after the ack is a new request.
- Minimum latency: req seen in IDLE at cycle 0 → ISSUE at 1 → WAIT at 2 → ack at 3. Each busy cycle adds 1.
- i_rdata and d_rdata hold their last value between acks. They are required valid only while ack=1.
- Only one ack is high in any cycle. Never more than one outstanding memory command.

Test Plan:
- Reset, then i_req=1, i_adr=0x100, mem_busy=0, data_from_mem=0xDEADBEEF → read_to_mem=1 with adr 0x100 during cycles 1–2; i_ack=1 at cycle 3 with i_rdata=0xDEADBEEF; d_ack stays 0.
- Both requests held from reset, memory never busy → grants alternate I, D, I, D; acks at cycles 3, 7, 11, 15.
- d_req with write=1, sel=0011, adr=0x2000, wdata=0x1234; mem_busy high for 5 WAIT cycles → write_to_mem held with stable fields through WAIT; d_ack 5 cycles later than the minimum; err=0.
- TIMEOUT=4, mem_busy stuck at 1 → after 4 WAIT cycles, ack and err pulse together with rdata=0; arbiter then accepts the next request normally.
- d_req with read=0, write=0 → d_ack 1 cycle after the request is sampled; no *_to_mem activity at any point.
- nRst driven low during WAIT of a port D read → all outputs 0 asynchronously; no ack afterwards; the first post-reset tie goes to port I.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: shares one memory port between instruction fetch (I)
// and data load/store (D) with round-robin tie-breaking and a busy timeout.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        i_req,
    input  logic [31:0] i_adr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_adr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        err,
    input  logic        mem_busy,
    input  logic [31:0] data_from_mem,
    output logic        read_to_mem,
    output logic        write_to_mem,
    output logic [3:0]  sel_to_mem,
    output logic [31:0] adr_to_mem,
    output logic [31:0] data_to_mem
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic        lastGrantD_q;
    logic        iAck_q;
    logic        dAck_q;
    logic        err_q;
    logic        readToMem_q;
    logic        writeToMem_q;
    logic [3:0]  selToMem_q;
    logic [31:0] adrToMem_q;
    logic [31:0] dataToMem_q;
    logic [31:0] iRdata_q;
    logic [31:0] dRdata_q;
    logic [7:0]  timeoutCnt_q;

    logic        anyReq_d;
    logic        pickD_d;
    logic        dNoop_d;
    logic        finish_d;

    always_comb begin
        anyReq_d = i_req | d_req;
        pickD_d  = d_req & (~i_req | ~lastGrantD_q);
        dNoop_d  = ~d_read & ~d_write;
        finish_d = ~mem_busy | (timeoutCnt_q == TIMEOUT_M1);
    end

    // The *_to_mem registers double as the latched command: loaded on grant,
    // held through ISSUE/WAIT and cleared on the way into DONE.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q      <= IDLE;
            lastGrantD_q <= 1'b1;
            iAck_q       <= 1'b0;
            dAck_q       <= 1'b0;
            err_q        <= 1'b0;
            readToMem_q  <= 1'b0;
            writeToMem_q <= 1'b0;
            selToMem_q   <= '0;
            adrToMem_q   <= '0;
            dataToMem_q  <= '0;
            iRdata_q     <= '0;
            dRdata_q     <= '0;
            timeoutCnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (anyReq_d) begin
                        lastGrantD_q <= pickD_d;
                        if (pickD_d && dNoop_d) begin
                            dAck_q   <= 1'b1;
                            dRdata_q <= '0;
                            state_q  <= DONE;
                        end else if (pickD_d) begin
                            readToMem_q  <= d_read & ~d_write;
                            writeToMem_q <= d_write;
                            selToMem_q   <= d_sel;
                            adrToMem_q   <= d_adr;
                            dataToMem_q  <= d_wdata;
                            state_q      <= ISSUE;
                        end else begin
                            readToMem_q  <= 1'b1;
                            writeToMem_q <= 1'b0;
                            selToMem_q   <= 4'b1111;
                            adrToMem_q   <= i_adr;
                            dataToMem_q  <= '0;
                            state_q      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A still-busy memory at this point means the timeout fired.
                    if (finish_d) begin
                        if (lastGrantD_q) begin
                            dRdata_q <= mem_busy ? '0 : data_from_mem;
                        end else begin
                            iRdata_q <= mem_busy ? '0 : data_from_mem;
                        end
                        iAck_q       <= ~lastGrantD_q;
                        dAck_q       <= lastGrantD_q;
                        err_q        <= mem_busy;
                        readToMem_q  <= 1'b0;
                        writeToMem_q <= 1'b0;
                        selToMem_q   <= '0;
                        adrToMem_q   <= '0;
                        dataToMem_q  <= '0;
                        state_q      <= DONE;
                    end
                    if (mem_busy) begin
                        timeoutCnt_q <= timeoutCnt_q + 8'd1;
                    end
                end
                DONE: begin
                    iAck_q       <= 1'b0;
                    dAck_q       <= 1'b0;
                    err_q        <= 1'b0;
                    timeoutCnt_q <= '0;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign i_ack        = iAck_q;
    assign d_ack        = dAck_q;
    assign err          = err_q;
    assign i_rdata      = iRdata_q;
    assign d_rdata      = dRdata_q;
    assign read_to_mem  = readToMem_q;
    assign write_to_mem = writeToMem_q;
    assign sel_to_mem   = selToMem_q;
    assign adr_to_mem   = adrToMem_q;
    assign data_to_mem  = dataToMem_q;

endmodule
